dimming_mode_scheduler: RTL and testbench

//  Sequences algorithm-mode changes for the backlight dimming datapath (MAX, AVG, WB, AVG+Enha).

---
 rtl/dimming_mode_scheduler_pkg.sv | 31 +++
 rtl/dimming_mode_scheduler_if.sv | 24 ++
 rtl/dimming_mode_scheduler_sw_debounce.sv | 46 ++++
 rtl/dimming_mode_scheduler.sv | 131 +++++++++++++
 tb/tb_dimming_mode_scheduler.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/dimming_mode_scheduler_pkg.sv
// Shared mode codes, FSM state encoding and the switch-code decoder for the dimming mode scheduler.
`default_nettype none

package dimming_mode_scheduler_pkg;

  localparam logic [3:0] MODE_MAX  = 4'b0001;
  localparam logic [3:0] MODE_AVG  = 4'b0010;
  localparam logic [3:0] MODE_WB   = 4'b0100;
  localparam logic [3:0] MODE_AVGE = 4'b1010;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PEND  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4,
    ST_APPLY = 3'd5
  } state_t;

  function automatic logic [3:0] decode_mode(input logic [1:0] code);
    case (code)
      2'b00:   decode_mode = MODE_MAX;
      2'b01:   decode_mode = MODE_AVG;
      2'b10:   decode_mode = MODE_WB;
      default: decode_mode = MODE_AVGE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dimming_mode_scheduler_if.sv
// Mode switch / datapath handshake bundle between the board side and the dimming datapath.
`default_nettype none

interface dimming_mode_scheduler_if;
  logic [1:0] sw;
  logic       frame_end;
  logic       busy;
  logic [3:0] mode;
  logic       flush;
  logic       mode_chg;
  logic       err;

  modport master (
    output sw, frame_end, busy,
    input  mode, flush, mode_chg, err
  );

  modport slave (
    input  sw, frame_end, busy,
    output mode, flush, mode_chg, err
  );
endinterface

`default_nettype wire

// File: rtl/dimming_mode_scheduler_sw_debounce.sv
// Two-flop synchroniser followed by a stability counter for the 2-bit mode switch.
`default_nettype none

module sw_debounce #(
  parameter int DEB_CYCLES = 50000,
  parameter int DEB_W      = 16
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  input  wire logic [1:0] sw,
  output logic      [1:0] stable,
  output logic            valid
);

  logic [1:0]       sync1;
  logic [1:0]       sync2;
  logic [1:0]       cand;
  logic [DEB_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 2'b00;
      sync2  <= 2'b00;
      cand   <= 2'b00;
      cnt    <= '0;
      stable <= 2'b00;
      valid  <= 1'b0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      // Counter saturates at the threshold so the accepted code keeps tracking the candidate.
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt == DEB_W'(DEB_CYCLES - 1)) begin
        stable <= cand;
        valid  <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/dimming_mode_scheduler.sv
// Defers debounced mode-switch changes to a frame boundary, flushes and drains the datapath, then applies the mode.
`default_nettype none

module dimming_mode_scheduler
  import dimming_mode_scheduler_pkg::*;
#(
  parameter int DEB_CYCLES = 50000,
  parameter int DEB_W      = 16,
  parameter int DRAIN_TO   = 1024,
  parameter int TO_W       = 11
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  dimming_mode_scheduler_if.slave bus
);

  logic [1:0] stable;
  logic       valid;

  sw_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .DEB_W      (DEB_W)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw     (bus.sw),
    .stable (stable),
    .valid  (valid)
  );

  state_t          state, state_n;
  logic [1:0]      target, target_n;
  logic [1:0]      applied;
  logic            pend_new, pend_new_n;
  logic            from_init, from_init_n;
  logic [TO_W-1:0] to_cnt, to_cnt_n;
  logic            err, err_n;
  logic [3:0]      mode;
  logic            flush;
  logic            mode_chg;

  always_comb begin
    state_n     = state;
    target_n    = target;
    pend_new_n  = 1'b0;
    from_init_n = from_init;
    to_cnt_n    = to_cnt;
    err_n       = err;
    case (state)
      ST_INIT: begin
        if (valid) begin
          state_n     = ST_PEND;
          target_n    = stable;
          pend_new_n  = 1'b1;
          from_init_n = 1'b1;
        end
      end
      ST_RUN: begin
        if (valid && stable != applied) begin
          state_n     = ST_PEND;
          target_n    = stable;
          pend_new_n  = 1'b1;
          from_init_n = 1'b0;
        end
      end
      ST_PEND: begin
        target_n = stable;
        // The reset value of the applied code is not a real mode, so never cancel back to it from INIT.
        if (!from_init && stable == applied) begin
          state_n = ST_RUN;
        end else if (bus.frame_end && !pend_new) begin
          state_n = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        state_n  = ST_DRAIN;
        to_cnt_n = '0;
      end
      ST_DRAIN: begin
        to_cnt_n = to_cnt + 1'b1;
        if (!bus.busy) begin
          state_n = ST_APPLY;
        end else if (to_cnt == TO_W'(DRAIN_TO - 1)) begin
          err_n   = 1'b1;
          state_n = ST_APPLY;
        end
      end
      ST_APPLY: begin
        state_n     = ST_RUN;
        from_init_n = 1'b0;
      end
      default: state_n = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      target    <= 2'b00;
      applied   <= 2'b00;
      pend_new  <= 1'b0;
      from_init <= 1'b0;
      to_cnt    <= '0;
      err       <= 1'b0;
      mode      <= 4'b0000;
      flush     <= 1'b0;
      mode_chg  <= 1'b0;
    end else begin
      state     <= state_n;
      target    <= target_n;
      pend_new  <= pend_new_n;
      from_init <= from_init_n;
      to_cnt    <= to_cnt_n;
      err       <= err_n;
      flush     <= (state_n == ST_FLUSH);
      mode_chg  <= (state_n == ST_APPLY);
      if (state_n == ST_APPLY) begin
        applied <= target;
        mode    <= decode_mode(target);
      end
    end
  end

  assign bus.mode     = mode;
  assign bus.flush    = flush;
  assign bus.mode_chg = mode_chg;
  assign bus.err      = err;

endmodule

`default_nettype wire

// File: tb/tb_dimming_mode_scheduler.sv
// Directed bench for dimming_mode_scheduler: mode-request table plus reset, bounce, cancel and timeout sequences.
`timescale 1ns/1ps
`default_nettype none

module tb_dimming_mode_scheduler;
  import dimming_mode_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dimming_mode_scheduler_if bus();

  dimming_mode_scheduler #(
    .DEB_CYCLES (4),
    .DEB_W      (3),
    .DRAIN_TO   (8),
    .TO_W       (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] sw;
    logic [3:0] exp_mode;
  } vec_t;

  vec_t       tbl [5];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] prev;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Outputs are sampled 1ns after the rising edge; inputs are driven at the same point.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outs(input string name);
    check({name, "_mode"},  bus.mode, 4'b0000);
    check({name, "_flush"}, {3'b000, bus.flush}, 4'b0000);
    check({name, "_chg"},   {3'b000, bus.mode_chg}, 4'b0000);
    check({name, "_err"},   {3'b000, bus.err}, 4'b0000);
  endtask

  // Request a new switch code, let it debounce and settle in PEND, then pulse frame end with busy low.
  task automatic do_change(input logic [1:0] code, input logic [3:0] exp_mode,
                           input logic [3:0] old_mode, input string name);
    bus.sw = code;
    repeat (12) cyc();
    check({name, "_preflush"}, {3'b000, bus.flush}, 4'b0000);
    check({name, "_hold"}, bus.mode, old_mode);
    bus.frame_end = 1'b1;
    cyc();
    bus.frame_end = 1'b0;
    check({name, "_flush1"}, {3'b000, bus.flush}, 4'b0001);
    cyc();
    check({name, "_flush0"}, {3'b000, bus.flush}, 4'b0000);
    check({name, "_drainhold"}, bus.mode, old_mode);
    cyc();
    check({name, "_mode"}, bus.mode, exp_mode);
    check({name, "_chg1"}, {3'b000, bus.mode_chg}, 4'b0001);
    cyc();
    check({name, "_chg0"}, {3'b000, bus.mode_chg}, 4'b0000);
    check({name, "_err"}, {3'b000, bus.err}, 4'b0000);
  endtask

  initial begin
    tbl[0] = '{sw: 2'b01, exp_mode: 4'b0010};
    tbl[1] = '{sw: 2'b11, exp_mode: 4'b1010};
    tbl[2] = '{sw: 2'b10, exp_mode: 4'b0100};
    tbl[3] = '{sw: 2'b00, exp_mode: 4'b0001};
    tbl[4] = '{sw: 2'b01, exp_mode: 4'b0010};

    bus.sw        = 2'b11;
    bus.frame_end = 1'b0;
    bus.busy      = 1'b0;

    // Reset held with a live switch and frame pulses.
    for (int i = 0; i < 6; i++) begin
      cyc();
      bus.frame_end = ~bus.frame_end;
      check_idle_outs("reset");
    end
    bus.frame_end = 1'b0;
    bus.sw        = 2'b01;
    cyc();
    rst_n = 1'b1;

    prev = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      do_change(tbl[i].sw, tbl[i].exp_mode, prev, $sformatf("tbl%0d", i));
      prev = tbl[i].exp_mode;
    end

    // Switch bounce with frame pulses sprinkled in: nothing may move.
    for (int i = 0; i < 32; i++) begin
      if (i < 20) bus.sw = (i % 4 < 2) ? 2'b10 : 2'b01;
      else        bus.sw = 2'b01;
      bus.frame_end = (i % 5 == 4);
      cyc();
      check("bounce_evt", {2'b00, bus.flush, bus.mode_chg}, 4'b0000);
    end
    bus.frame_end = 1'b0;
    check("bounce_mode", bus.mode, 4'b0010);

    // Retarget while pending: 11 then 10 before the frame end.
    bus.sw = 2'b11;
    for (int i = 0; i < 12; i++) begin
      cyc();
      check("retarget_noflush", {3'b000, bus.flush}, 4'b0000);
    end
    do_change(2'b10, MODE_WB, MODE_AVG, "retarget");

    // Pending 00 then back to the applied 10: must cancel to RUN.
    bus.sw = 2'b00;
    repeat (12) cyc();
    bus.sw = 2'b10;
    repeat (12) cyc();
    bus.frame_end = 1'b1;
    cyc();
    bus.frame_end = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("cancel_evt", {2'b00, bus.flush, bus.mode_chg}, 4'b0000);
      cyc();
    end
    check("cancel_mode", bus.mode, MODE_WB);

    // Drain timeout with busy stuck high.
    bus.sw = 2'b00;
    repeat (12) cyc();
    bus.busy      = 1'b1;
    bus.frame_end = 1'b1;
    cyc();
    bus.frame_end = 1'b0;
    check("to_flush", {3'b000, bus.flush}, 4'b0001);
    repeat (8) cyc();
    check("to_mode_hold", bus.mode, MODE_WB);
    check("to_err_pre", {3'b000, bus.err}, 4'b0000);
    cyc();
    check("to_mode", bus.mode, MODE_MAX);
    check("to_chg", {3'b000, bus.mode_chg}, 4'b0001);
    check("to_err", {3'b000, bus.err}, 4'b0001);
    bus.busy = 1'b0;
    repeat (5) cyc();
    check("to_err_sticky", {3'b000, bus.err}, 4'b0001);

    // Reset asserted in the middle of DRAIN.
    bus.sw = 2'b01;
    repeat (12) cyc();
    bus.busy      = 1'b1;
    bus.frame_end = 1'b1;
    cyc();
    bus.frame_end = 1'b0;
    check("rd_flush", {3'b000, bus.flush}, 4'b0001);
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outs("rd_async");
    bus.busy = 1'b0;
    bus.sw   = 2'b00;
    cyc();
    cyc();
    check_idle_outs("rd_held");
    rst_n = 1'b1;
    bus.frame_end = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rd_init_noflush", {3'b000, bus.flush}, 4'b0000);
    end
    bus.frame_end = 1'b0;
    // INIT-origin request for 00 must not be cancelled against the cleared applied code.
    do_change(2'b00, MODE_MAX, 4'b0000, "rd_init");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
